// File: rtl/rom_loader_gen.sv
// ioctl download router into NREG back-to-back ROM regions (8/16/32-bit targets); write request one cycle after ioctl_wr.
// Backpressure: rom_we held until rom_ack; ioctl_wait stalls the host while a bus cycle is pending.
module rom_loader_gen #(
    parameter int                 NREG        = 6,
    parameter int                 AW          = 26,
    parameter logic [NREG*AW-1:0] REGION_LEN  = {NREG{AW'(32'h10000)}},
    parameter logic [NREG*AW-1:0] REGION_OFFS = {NREG{AW'(32'h0)}},
    parameter logic [NREG*2-1:0]  REGION_MODE = {NREG{2'd1}}
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic [AW-1:0]   ioctl_addr,
    input  logic [15:0]     ioctl_dout,
    input  logic            ioctl_wr,
    input  logic            load_en,
    output logic            ioctl_wait,
    output logic [NREG-1:0] rom_we,
    output logic [AW-1:0]   rom_addr,
    output logic [31:0]     rom_data,
    output logic [3:0]      rom_be,
    input  logic            rom_ack,
    output logic            load_done,
    output logic            load_err
);

    // Extra headroom bits so the running sum of lengths cannot wrap.
    localparam int BW = AW + 4;

    function automatic logic [(NREG+1)*BW-1:0] calc_bases();
        logic [(NREG+1)*BW-1:0] b;
        logic [BW-1:0]          acc;
        b   = '0;
        acc = '0;
        for (int i = 0; i < NREG; i++) begin
            acc = acc + BW'(REGION_LEN[i*AW +: AW]);
            b[(i+1)*BW +: BW] = acc;
        end
        return b;
    endfunction

    localparam logic [(NREG+1)*BW-1:0] BASES = calc_bases();

    typedef enum logic [1:0] {IDLE, WRITE, SPLIT2, WRITE2} state_t;

    state_t          state_q;
    logic [NREG-1:0] we_q;
    logic [NREG-1:0] sel_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     data_q;
    logic [3:0]      be_q;
    logic [7:0]      hi_q;
    logic            split_q;
    logic            pack_vld_q;
    logic [15:0]     pack_low_q;
    logic [AW-1:0]   pack_addr_q;
    logic [NREG-1:0] pack_sel_q;
    logic            load_en_q;
    logic            active_q;
    logic            done_q;
    logic            err_q;

    logic            hit;
    logic [NREG-1:0] sel_oh;
    logic [1:0]      mode;
    logic [AW-1:0]   rel;
    logic [AW-1:0]   dest;
    logic            wr_req;
    logic            need_bus;

    // Zero-length regions never hit, so the first match is the lowest valid region.
    always_comb begin
        hit    = 1'b0;
        sel_oh = '0;
        mode   = 2'd0;
        rel    = '0;
        dest   = '0;
        for (int i = 0; i < NREG; i++) begin
            if (!hit && BW'(ioctl_addr) >= BASES[i*BW +: BW]
                     && BW'(ioctl_addr) <  BASES[(i+1)*BW +: BW]) begin
                hit       = 1'b1;
                sel_oh[i] = 1'b1;
                mode      = REGION_MODE[i*2 +: 2];
                rel       = ioctl_addr - BASES[i*BW +: AW];
                dest      = rel + REGION_OFFS[i*AW +: AW];
            end
        end
    end

    assign wr_req   = ioctl_wr & load_en;
    assign need_bus = hit & ((mode == 2'd0) | (mode == 2'd1) | ((mode == 2'd2) & rel[1]));

    assign ioctl_wait = (state_q != IDLE) | (wr_req & need_bus);
    assign rom_we     = we_q;
    assign rom_addr   = addr_q;
    assign rom_data   = data_q;
    assign rom_be     = be_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= '0;
            sel_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
            hi_q        <= '0;
            split_q     <= 1'b0;
            pack_vld_q  <= 1'b0;
            pack_low_q  <= '0;
            pack_addr_q <= '0;
            pack_sel_q  <= '0;
            load_en_q   <= 1'b0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            load_en_q <= load_en;
            if (load_en && !load_en_q) begin
                done_q     <= 1'b0;
                err_q      <= 1'b0;
                pack_vld_q <= 1'b0;
                pack_low_q <= '0;
                active_q   <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (wr_req) begin
                        if (!hit || mode == 2'd3) begin
                            err_q <= 1'b1;
                        end else if (mode == 2'd0) begin
                            we_q    <= sel_oh;
                            sel_q   <= sel_oh;
                            addr_q  <= dest;
                            data_q  <= {24'h0, ioctl_dout[7:0]};
                            be_q    <= 4'b0001;
                            hi_q    <= ioctl_dout[15:8];
                            split_q <= 1'b1;
                            state_q <= WRITE;
                        end else if (mode == 2'd1) begin
                            we_q    <= sel_oh;
                            addr_q  <= dest >> 1;
                            data_q  <= {16'h0, ioctl_dout};
                            be_q    <= 4'b0011;
                            split_q <= 1'b0;
                            state_q <= WRITE;
                        end else if (!rel[1]) begin
                            pack_vld_q  <= 1'b1;
                            pack_low_q  <= ioctl_dout;
                            pack_addr_q <= dest >> 2;
                            pack_sel_q  <= sel_oh;
                        end else begin
                            we_q       <= sel_oh;
                            addr_q     <= dest >> 2;
                            data_q     <= {ioctl_dout, pack_low_q};
                            be_q       <= 4'b1111;
                            split_q    <= 1'b0;
                            pack_vld_q <= 1'b0;
                            pack_low_q <= '0;
                            state_q    <= WRITE;
                        end
                    end else if (!load_en && pack_vld_q) begin
                        // Download ended on an odd 16-bit word: push the lone low half.
                        we_q       <= pack_sel_q;
                        addr_q     <= pack_addr_q;
                        data_q     <= {16'h0, pack_low_q};
                        be_q       <= 4'b0011;
                        split_q    <= 1'b0;
                        pack_vld_q <= 1'b0;
                        pack_low_q <= '0;
                        state_q    <= WRITE;
                    end else if (!load_en && active_q) begin
                        done_q   <= 1'b1;
                        active_q <= 1'b0;
                    end
                end
                WRITE: begin
                    if (rom_ack) begin
                        we_q    <= '0;
                        state_q <= split_q ? SPLIT2 : IDLE;
                    end
                end
                SPLIT2: begin
                    we_q    <= sel_q;
                    addr_q  <= addr_q + AW'(1);
                    data_q  <= {24'h0, hi_q};
                    be_q    <= 4'b0001;
                    split_q <= 1'b0;
                    state_q <= WRITE2;
                end
                WRITE2: begin
                    if (rom_ack) begin
                        we_q    <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (wr_req && state_q != IDLE) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_loader_gen.sv
// Directed bench for rom_loader_gen: 16/8/32-bit regions, ack stall, range error, flush and reset mid-split.
module tb_rom_loader_gen;

    localparam int NREG = 3;
    localparam int AW   = 26;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic [AW-1:0]   ioctl_addr;
    logic [15:0]     ioctl_dout;
    logic            ioctl_wr;
    logic            load_en;
    logic            ioctl_wait;
    logic [NREG-1:0] rom_we;
    logic [AW-1:0]   rom_addr;
    logic [31:0]     rom_data;
    logic [3:0]      rom_be;
    logic            rom_ack;
    logic            load_done;
    logic            load_err;

    int checks = 0;
    int errors = 0;

    rom_loader_gen #(
        .NREG       (NREG),
        .AW         (AW),
        .REGION_LEN ({26'h0040000, 26'h0008000, 26'h0040000}),
        .REGION_OFFS({26'h1000000, 26'h0000000, 26'h0000000}),
        .REGION_MODE({2'd2, 2'd0, 2'd1})
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout),
        .ioctl_wr  (ioctl_wr),
        .load_en   (load_en),
        .ioctl_wait(ioctl_wait),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rom_be    (rom_be),
        .rom_ack   (rom_ack),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Drives one strobe; returns #1 after the edge that samples it.
    task automatic ioctl_write(input logic [AW-1:0] a, input logic [15:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic check_wr(input string tag, input logic [2:0] we, input logic [AW-1:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        check({tag, "_we"},   32'(rom_we),   32'(we));
        check({tag, "_addr"}, 32'(rom_addr), 32'(a));
        check({tag, "_data"}, rom_data,      d);
        check({tag, "_be"},   32'(rom_be),   32'(be));
    endtask

    initial begin
        reset      = 1'b1;
        ioctl_addr = '0;
        ioctl_dout = '0;
        ioctl_wr   = 1'b0;
        load_en    = 1'b0;
        rom_ack    = 1'b1;
        #1;
        tick();
        tick();
        check_wr("rst", 3'b000, '0, 32'h0, 4'h0);
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_done", 32'(load_done),  32'd0);
        check("rst_err",  32'(load_err),   32'd0);
        reset   = 1'b0;
        load_en = 1'b1;
        tick();

        // 16-bit region: single one-cycle write.
        ioctl_addr = 26'h000102;
        ioctl_dout = 16'hBEEF;
        ioctl_wr   = 1'b1;
        #1;
        check("t1_wait_strobe", 32'(ioctl_wait), 32'd1);
        tick();
        ioctl_wr = 1'b0;
        check_wr("t1", 3'b001, 26'h81, 32'h0000BEEF, 4'b0011);
        tick();
        check("t1_we_drop", 32'(rom_we),     32'd0);
        check("t1_wait_end", 32'(ioctl_wait), 32'd0);

        // 8-bit region: split into two byte writes.
        ioctl_write(26'h040010, 16'h1234);
        check_wr("t2a", 3'b010, 26'h10, 32'h34, 4'b0001);
        check("t2a_wait", 32'(ioctl_wait), 32'd1);
        tick();
        check("t2_gap_we",   32'(rom_we),     32'd0);
        check("t2_gap_wait", 32'(ioctl_wait), 32'd1);
        tick();
        check_wr("t2b", 3'b010, 26'h11, 32'h12, 4'b0001);
        check("t2b_wait", 32'(ioctl_wait), 32'd1);
        tick();
        check("t2_end_we",   32'(rom_we),     32'd0);
        check("t2_end_wait", 32'(ioctl_wait), 32'd0);

        // 32-bit region: two words pack into one write.
        ioctl_addr = 26'h048000;
        ioctl_dout = 16'hAAAA;
        ioctl_wr   = 1'b1;
        #1;
        check("t3_wait_lo", 32'(ioctl_wait), 32'd0);
        tick();
        ioctl_wr = 1'b0;
        check("t3_no_we", 32'(rom_we), 32'd0);
        ioctl_write(26'h048002, 16'h5555);
        check_wr("t3", 3'b100, 26'h400000, 32'h5555AAAA, 4'b1111);
        tick();
        check("t3_we_drop", 32'(rom_we), 32'd0);

        // Ack stall with a busy write in the middle.
        rom_ack = 1'b0;
        ioctl_write(26'h000200, 16'h1111);
        for (int k = 0; k < 3; k++) begin
            if (k == 0) ioctl_write(26'h000204, 16'h2222);
            else        tick();
            check_wr("t4_hold", 3'b001, 26'h100, 32'h00001111, 4'b0011);
            check("t4_wait", 32'(ioctl_wait), 32'd1);
        end
        rom_ack = 1'b1;
        tick();
        check("t4_we_drop", 32'(rom_we),   32'd0);
        check("t4_err",     32'(load_err), 32'd1);
        tick();
        check("t4_no_extra", 32'(rom_we), 32'd0);

        // Fall then rise: done on fall, rise clears done and err.
        load_en = 1'b0;
        tick();
        check("t5_done_fall", 32'(load_done), 32'd1);
        load_en = 1'b1;
        tick();
        check("t5_done_clr", 32'(load_done), 32'd0);
        check("t5_err_clr",  32'(load_err),  32'd0);

        // Out of range.
        ioctl_addr = 26'h088000;
        ioctl_dout = 16'h9999;
        ioctl_wr   = 1'b1;
        #1;
        check("t5_wait_oor", 32'(ioctl_wait), 32'd0);
        tick();
        ioctl_wr = 1'b0;
        check("t5_no_we", 32'(rom_we),   32'd0);
        check("t5_err",   32'(load_err), 32'd1);
        load_en = 1'b0;
        tick();
        load_en = 1'b1;
        tick();
        check("t5_err_rise_clr", 32'(load_err), 32'd0);

        // Odd end of a 32-bit region: flush on load_en fall.
        ioctl_write(26'h048004, 16'h7777);
        check("t6_no_we", 32'(rom_we), 32'd0);
        load_en = 1'b0;
        tick();
        check_wr("t6_flush", 3'b100, 26'h400001, 32'h00007777, 4'b0011);
        check("t6_done_early", 32'(load_done), 32'd0);
        tick();
        check("t6_we_drop", 32'(rom_we),    32'd0);
        tick();
        check("t6_done",    32'(load_done), 32'd1);
        load_en = 1'b1;
        tick();
        check("t6_done_clr", 32'(load_done), 32'd0);

        // Reset during an 8-bit split: second byte must never appear.
        ioctl_write(26'h040020, 16'hABCD);
        check_wr("t7a", 3'b010, 26'h20, 32'hCD, 4'b0001);
        reset = 1'b1;
        tick();
        check("t7_we_rst", 32'(rom_we), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t7_no_second", 32'(rom_we), 32'd0);
        end
        check("t7_wait", 32'(ioctl_wait), 32'd0);
        check("t7_err",  32'(load_err),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
